// File: rtl/cdb_pkg.sv
// -----------------------------------------------------------------------------
// cdb_pkg
// Shared definitions for the CDB / register-file writeback path.
//   XLEN, TAG_W, NUM_SRC, REG_AW : datapath widths and source count
//   cdb_pkt_t                    : one registered broadcast (valid, tag, rd, data)
//   SRC_ALU..SRC_LOAD            : fixed source index of each functional unit
// -----------------------------------------------------------------------------
package cdb_pkg;

  localparam int XLEN    = 32;
  localparam int TAG_W   = 4;
  localparam int NUM_SRC = 4;
  localparam int REG_AW  = 5;

  localparam int SRC_ALU  = 0;
  localparam int SRC_MUL  = 1;
  localparam int SRC_DIV  = 2;
  localparam int SRC_LOAD = 3;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } cdb_pkt_t;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick. The search starts at ptr and walks
// ptr, ptr+1, ... modulo N; the first requester found wins.
//   req       in  N   request vector
//   ptr       in  PW  highest-priority index for this cycle
//   grant     out N   one-hot grant, zero when nothing requests
//   grant_idx out PW  encoded winner (0 when nothing requests)
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] grant_idx
);

  // cand_idx[k] is the source examined at search offset k, i.e. (ptr+k) mod N.
  logic [PW-1:0] cand_idx [N];
  logic [N-1:0]  req_rot;
  logic          found;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_off
      logic [PW:0] sum;
      assign sum          = {1'b0, ptr} + (PW+1)'(gi);
      // One conditional subtract is enough: ptr < N and gi < N.
      assign cand_idx[gi] = (sum >= (PW+1)'(N)) ? PW'(sum - (PW+1)'(N)) : sum[PW-1:0];
      assign req_rot[gi]  = req[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    grant_idx = '0;
    found     = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && req_rot[k]) begin
        found     = 1'b1;
        grant_idx = cand_idx[k];
      end
    end
    grant = found ? (N'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/cdb_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_writeback_arbiter
// Collects completed results from NUM_SRC functional units and registers one
// per cycle onto the CDB broadcast and the register-file write port. Outputs
// come straight from posedge registers so the register file can sample them on
// the following negedge.
//   clk, reset                   clock, asynchronous active-high reset
//   src_valid / src_ready        per-source handshake (ready is combinational)
//   src_tag / src_rd / src_data  packed per-source payload, source i at slot i
//   cdb_hold                     freeze the output stage, pointer and counter
//   flush                        squash: no grant, output valid cleared
//   cdb_valid/cdb_tag/cdb_data   CDB broadcast
//   RegWrite/writeaddr/writedata register-file write port (never writes x0)
//   bcast_count                  completed broadcasts, wraps modulo 2^32
// -----------------------------------------------------------------------------
module cdb_writeback_arbiter #(
  parameter int NUM_SRC = cdb_pkg::NUM_SRC,
  parameter int TAG_W   = cdb_pkg::TAG_W,
  parameter int XLEN    = cdb_pkg::XLEN
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_SRC-1:0]                src_valid,
  output logic [NUM_SRC-1:0]                src_ready,
  input  logic [NUM_SRC*TAG_W-1:0]          src_tag,
  input  logic [NUM_SRC*cdb_pkg::REG_AW-1:0] src_rd,
  input  logic [NUM_SRC*XLEN-1:0]           src_data,
  input  logic                              cdb_hold,
  input  logic                              flush,
  output logic                              cdb_valid,
  output logic [TAG_W-1:0]                  cdb_tag,
  output logic [XLEN-1:0]                   cdb_data,
  output logic                              RegWrite,
  output logic [cdb_pkg::REG_AW-1:0]        writeaddr,
  output logic [XLEN-1:0]                   writedata,
  output logic [31:0]                       bcast_count
);

  import cdb_pkg::*;

  localparam int PW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  // Unpacked views of the per-source payload buses.
  logic [TAG_W-1:0]  tag_arr  [NUM_SRC];
  logic [REG_AW-1:0] rd_arr   [NUM_SRC];
  logic [XLEN-1:0]   data_arr [NUM_SRC];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
      assign tag_arr[gi]  = src_tag[gi*TAG_W +: TAG_W];
      assign rd_arr[gi]   = src_rd[gi*REG_AW +: REG_AW];
      assign data_arr[gi] = src_data[gi*XLEN +: XLEN];
    end
  endgenerate

  cdb_pkt_t      pkt_q, pkt_d;
  logic          we_q, we_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [31:0]   cnt_q, cnt_d;

  logic [NUM_SRC-1:0] grant_oh;
  logic [PW-1:0]      grant_idx;
  logic               grant_block;
  logic               xfer;

  rr_arbiter #(.N(NUM_SRC)) u_arb (
    .req       (src_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant_oh),
    .grant_idx (grant_idx)
  );

  // Reset is included so a source never sees an accept that the reset erases.
  assign grant_block = cdb_hold | flush | reset;
  assign src_ready   = grant_block ? '0 : grant_oh;
  assign xfer        = |(src_valid & src_ready);

  always_comb begin
    pkt_d    = pkt_q;
    we_d     = we_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      // Flush wins over hold; payload is left as-is since valid is cleared.
      pkt_d.valid = 1'b0;
      we_d        = 1'b0;
    end else if (!cdb_hold) begin
      if (xfer) begin
        pkt_d.valid = 1'b1;
        pkt_d.tag   = tag_arr[grant_idx];
        pkt_d.rd    = rd_arr[grant_idx];
        pkt_d.data  = data_arr[grant_idx];
        // A result aimed at x0 still broadcasts its tag but must not write.
        we_d        = |rd_arr[grant_idx];
        rr_ptr_d    = (grant_idx == PW'(NUM_SRC-1)) ? '0 : grant_idx + PW'(1);
        cnt_d       = cnt_q + 32'd1;
      end else begin
        pkt_d.valid = 1'b0;
        we_d        = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_q    <= '0;
      we_q     <= 1'b0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      pkt_q    <= pkt_d;
      we_q     <= we_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign cdb_valid   = pkt_q.valid;
  assign cdb_tag     = pkt_q.tag;
  assign cdb_data    = pkt_q.data;
  assign RegWrite    = we_q;
  assign writeaddr   = pkt_q.rd;
  assign writedata   = pkt_q.data;
  assign bcast_count = cnt_q;

endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_writeback_arbiter
// Directed scenarios followed by randomized traffic, checked against a
// behavioural model of the writeback stage and a small register file that
// captures the write port on negedge clk.
// -----------------------------------------------------------------------------
module tb_cdb_writeback_arbiter;

  import cdb_pkg::*;

  localparam int N = NUM_SRC;

  logic                clk = 1'b0;
  logic                reset;
  logic [N-1:0]        src_valid;
  logic [N-1:0]        src_ready;
  logic [N*TAG_W-1:0]  src_tag;
  logic [N*REG_AW-1:0] src_rd;
  logic [N*XLEN-1:0]   src_data;
  logic                cdb_hold;
  logic                flush;
  logic                cdb_valid;
  logic [TAG_W-1:0]    cdb_tag;
  logic [XLEN-1:0]     cdb_data;
  logic                RegWrite;
  logic [REG_AW-1:0]   writeaddr;
  logic [XLEN-1:0]     writedata;
  logic [31:0]         bcast_count;

  always #5 clk = ~clk;

  cdb_writeback_arbiter #(.NUM_SRC(N), .TAG_W(TAG_W), .XLEN(XLEN)) dut (
    .clk         (clk),
    .reset       (reset),
    .src_valid   (src_valid),
    .src_ready   (src_ready),
    .src_tag     (src_tag),
    .src_rd      (src_rd),
    .src_data    (src_data),
    .cdb_hold    (cdb_hold),
    .flush       (flush),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .cdb_data    (cdb_data),
    .RegWrite    (RegWrite),
    .writeaddr   (writeaddr),
    .writedata   (writedata),
    .bcast_count (bcast_count)
  );

  // Register file fed by the write port, sampled on negedge.
  logic [XLEN-1:0] tb_rf [32];
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) tb_rf[i] <= '0;
    end else if (RegWrite) begin
      tb_rf[writeaddr] <= writedata;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural model state.
  int          m_ptr;
  int          m_g;
  logic [31:0] m_cnt;
  logic        m_valid;
  logic        m_we;
  logic [TAG_W-1:0]  m_tag;
  logic [REG_AW-1:0] m_rd;
  logic [XLEN-1:0]   m_data;

  task automatic model_reset();
    m_ptr   = 0;
    m_g     = -1;
    m_cnt   = '0;
    m_valid = 1'b0;
    m_we    = 1'b0;
    m_tag   = '0;
    m_rd    = '0;
    m_data  = '0;
  endtask

  task automatic check_outputs(input string ph);
    chk({ph, "_cdb_valid"}, 64'(cdb_valid), 64'(m_valid));
    chk({ph, "_cdb_tag"}, 64'(cdb_tag), 64'(m_tag));
    chk({ph, "_cdb_data"}, 64'(cdb_data), 64'(m_data));
    chk({ph, "_RegWrite"}, 64'(RegWrite), 64'(m_we));
    chk({ph, "_writeaddr"}, 64'(writeaddr), 64'(m_rd));
    chk({ph, "_writedata"}, 64'(writedata), 64'(m_data));
    chk({ph, "_bcast_count"}, 64'(bcast_count), 64'(m_cnt));
  endtask

  task automatic set_src(input int i, input logic [TAG_W-1:0] t,
                         input logic [REG_AW-1:0] r, input logic [XLEN-1:0] d);
    src_tag[i*TAG_W +: TAG_W]   = t;
    src_rd[i*REG_AW +: REG_AW]  = r;
    src_data[i*XLEN +: XLEN]    = d;
  endtask

  // One cycle: check the combinational grant, advance the model, clock, check.
  task automatic step();
    logic [N-1:0] exp_ready;
    #1;
    m_g = -1;
    if (!cdb_hold && !flush && !reset) begin
      for (int i = 0; i < N; i++) begin
        int s;
        s = (m_ptr + i) % N;
        if (m_g < 0 && src_valid[s]) m_g = s;
      end
    end
    exp_ready = (m_g >= 0) ? N'(1) << m_g : '0;
    chk("src_ready", 64'(src_ready), 64'(exp_ready));
    if (flush) begin
      m_valid = 1'b0;
      m_we    = 1'b0;
    end else if (!cdb_hold) begin
      if (m_g >= 0) begin
        m_valid = 1'b1;
        m_tag   = src_tag[m_g*TAG_W +: TAG_W];
        m_rd    = src_rd[m_g*REG_AW +: REG_AW];
        m_data  = src_data[m_g*XLEN +: XLEN];
        m_we    = (m_rd != 0);
        m_ptr   = (m_g + 1) % N;
        m_cnt   = m_cnt + 32'd1;
      end else begin
        m_valid = 1'b0;
        m_we    = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check_outputs("cyc");
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs("rst");
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  int wait_cnt [N];

  initial begin
    reset     = 1'b1;
    src_valid = '1;
    src_tag   = '0;
    src_rd    = '0;
    src_data  = '0;
    cdb_hold  = 1'b0;
    flush     = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    chk("ready_in_reset", 64'(src_ready), 64'(0));
    src_valid = '0;
    @(negedge clk);
    #1;
    reset = 1'b0;

    // Single source (MUL).
    set_src(SRC_MUL, 4'd2, 5'd7, 32'h1234_5678);
    src_valid = 4'b0010;
    step();
    src_valid = '0;
    @(negedge clk);
    #1;
    chk("rf_x7", 64'(tb_rf[7]), 64'h1234_5678);

    // Round-robin with all sources continuously valid from pointer 0.
    do_reset();
    for (int i = 0; i < N; i++) set_src(i, TAG_W'(i + 4), REG_AW'(i + 10), $urandom);
    src_valid = '1;
    for (int k = 0; k < 5; k++) step();
    chk("rr_count5", 64'(bcast_count), 64'd5);
    src_valid = '0;

    // x0 destination from LOAD.
    set_src(SRC_LOAD, 4'd9, 5'd0, 32'hFFFF_FFFF);
    src_valid = 4'b1000;
    step();
    src_valid = '0;
    @(negedge clk);
    #1;
    chk("rf_x0", 64'(tb_rf[0]), 64'd0);

    // Hold for three cycles with ALU requesting, then release.
    set_src(SRC_ALU, 4'd1, 5'd3, 32'h0000_0011);
    src_valid = 4'b0001;
    step();
    set_src(SRC_ALU, 4'd5, 5'd4, 32'h0000_0022);
    cdb_hold = 1'b1;
    repeat (3) step();
    cdb_hold = 1'b0;
    step();
    src_valid = '0;

    // Flush together with hold, DIV requesting.
    set_src(SRC_DIV, 4'd6, 5'd8, 32'h0000_0033);
    src_valid = 4'b0100;
    cdb_hold  = 1'b1;
    flush     = 1'b1;
    step();
    cdb_hold = 1'b0;
    flush    = 1'b0;
    step();
    src_valid = '0;
    step();

    // Reset asserted the cycle after a broadcast, no clock edge needed.
    set_src(SRC_ALU, 4'd3, 5'd5, 32'hDEAD_BEEF);
    src_valid = 4'b0001;
    step();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs("midrst");
    chk("ready_midrst", 64'(src_ready), 64'd0);
    src_valid = '0;
    @(negedge clk);
    #1;
    reset = 1'b0;

    // Randomized traffic; sources keep valid and payload until accepted.
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!src_valid[i] && $urandom_range(0, 1) == 1) begin
          logic [REG_AW-1:0] r;
          r = ($urandom_range(0, 3) == 0) ? '0 : REG_AW'($urandom_range(1, 31));
          set_src(i, TAG_W'($urandom), r, $urandom);
          src_valid[i] = 1'b1;
        end
      end
      cdb_hold = ($urandom_range(0, 4) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      step();
      if (!cdb_hold && !flush) begin
        for (int i = 0; i < N; i++) begin
          if (src_valid[i]) begin
            if (i == m_g) begin
              chk("fairness", 64'(wait_cnt[i] < N), 64'd1);
              wait_cnt[i] = 0;
            end else begin
              wait_cnt[i]++;
            end
          end
        end
      end
      if (m_g >= 0) src_valid[m_g] = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cdb_writeback_arbiter.md
Name: cdb_writeback_arbiter

Overview:
Write-side producer for the architectural register file and the common data bus (CDB) in the Tomasulo core. It collects completed results from NUM_SRC functional units through valid/ready handshakes. A round-robin arbiter grants one source per cycle, and the granted result is registered onto the CDB broadcast and the register-file write port (RegWrite/writeaddr/writedata). The register file samples that port on negedge clk, so outputs are driven from posedge registers and are stable for the whole cycle.

Parameters:
NUM_SRC, 4, number of result sources (0=ALU, 1=MUL, 2=DIV, 3=LOAD)
TAG_W, 4, reservation-station tag width broadcast on the CDB
XLEN, 32, data width

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
src_valid  in  NUM_SRC  per-source result valid
src_ready  out  NUM_SRC  per-source grant, one-hot or zero, combinational
src_tag  in  NUM_SRC*TAG_W  packed producer tags; source i occupies [i*TAG_W +: TAG_W]
src_rd  in  NUM_SRC*5  packed destination register numbers
src_data  in  NUM_SRC*XLEN  packed result data
cdb_hold  in  1  downstream stall; freeze the output stage
flush  in  1  mispredict/exception squash
cdb_valid  out  1  CDB broadcast valid
cdb_tag  out  TAG_W  broadcast tag
cdb_data  out  XLEN  broadcast data
RegWrite  out  1  register-file write enable
writeaddr  out  5  register-file write address
writedata  out  XLEN  register-file write data
bcast_count  out  32  number of completed broadcasts, wraps modulo 2^32

Behaviour:
- Reset (asynchronous, active-high):
  - cdb_valid=0, cdb_tag=0, cdb_data=0.
  - RegWrite=0, writeaddr=0, writedata=0.
  - rr_ptr=0, bcast_count=0.
  - src_ready=0 while reset is high.
  - A grant in flight when reset asserts is dropped; the source is not considered accepted.
- Grant (combinational):
  - src_ready[i]=1 only for the first i with src_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_SRC.
  - All grants are forced to 0 when cdb_hold=1, flush=1 or reset=1.
- Transfer: src_valid[i] & src_ready[i]. Sources must hold valid and payload stable until the transfer; dropping valid early is a protocol error.
- Posedge with a transfer from source g (latency 1 cycle):
  - cdb_valid=1; cdb_tag, cdb_data, writeaddr, writedata load from g.
  - RegWrite=(src_rd[g]!=0). rd=0 still broadcasts its tag on the CDB but never writes.
  - rr_ptr=(g+1) mod NUM_SRC.
  - bcast_count increments by 1.
- Posedge with no transfer, hold=0 and flush=0:
  - cdb_valid=0, RegWrite=0.
  - Payload registers keep their last values; they are don't-care but must not be X.
  - rr_ptr is unchanged.
- cdb_hold=1 and flush=0:
  - All output registers, rr_ptr and bcast_count hold.
  - A held valid broadcast therefore repeats; this is idempotent for both the register file and the reservation stations.
- flush=1 (overrides hold):
  - No grant that cycle.
  - Next cycle cdb_valid=0 and RegWrite=0.
  - rr_ptr is unchanged; bcast_count is unchanged.
- Fairness: any continuously valid source is granted within NUM_SRC cycles in which hold and flush are both 0.
- Simultaneous requests from all sources with rr_ptr=k: the grant order is k, k+1, ..., wrapping.
- At most one register-file write per cycle; no write ever targets x0.

Decomposition:
- Shared package cdb_pkg holds:
  - localparams XLEN, TAG_W, NUM_SRC, REG_AW=5;
  - typedef cdb_pkt_t {valid, tag, rd, data};
  - source-index constants SRC_ALU, SRC_MUL, SRC_DIV, SRC_LOAD.
- One natural sub-module, rr_arbiter #(N): inputs req[N] and ptr, outputs one-hot grant and encoded grant index. Purely combinational; rr_ptr lives in the parent.

Test Plan:
- Reset mid-broadcast: drive ALU valid tag=3 rd=5 data=0xDEADBEEF, then assert reset in the next cycle -> cdb_valid=0, RegWrite=0, writeaddr=0 and bcast_count=0 immediately, with no clock edge needed.
- Single source: after reset, MUL valid tag=2 rd=7 data=0x12345678 -> src_ready=4'b0010 same cycle; next cycle cdb_valid=1, cdb_tag=2, RegWrite=1, writeaddr=7, writedata=0x12345678; register x7 reads 0x12345678 after the negedge.
- Round-robin: all four sources valid continuously from rr_ptr=0 -> grants 0,1,2,3,0 on consecutive cycles; bcast_count=5 after 5 grants.
- x0 destination: LOAD valid tag=9 rd=0 data=0xFFFFFFFF -> cdb_valid=1, cdb_tag=9, RegWrite=0; x0 still reads 0.
- Hold: broadcast tag=1 pending, cdb_hold=1 for 3 cycles with ALU valid -> outputs frozen, src_ready=0 throughout; the first cycle after hold drops, the ALU is granted.
- Flush over hold: cdb_hold=1 and flush=1 together with DIV valid -> src_ready=0; next cycle cdb_valid=0, RegWrite=0; rr_ptr and bcast_count unchanged.
